tree_loader: RTL

//  Host-side writer for the treeval sideband load interface. Accepts packed 32-bit node words on a

---
 rtl/tree_loader_pkg.sv | 54 +++++
 rtl/tree_node_unpack.sv | 25 ++
 rtl/tree_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tree_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tree_loader_pkg
// Brief    : Shared node-word field layout, widths and loader state encoding
//            for the treeval sideband loader.
// Revision : 1.0 - initial release
// ============================================================================
package tree_loader_pkg;

  // Packed node word geometry
  localparam int c_node_size = 32;
  localparam int c_w_addr    = 10;
  localparam int c_w_parent  = 10;
  localparam int c_w_action  = 3;
  localparam int c_w_reward  = 10;
  localparam int c_w_weight  = 8;

  // Field positions inside the packed node word
  localparam int c_parent_hi = 31;
  localparam int c_parent_lo = 22;
  localparam int c_action_hi = 21;
  localparam int c_action_lo = 19;
  localparam int c_strat_bit = 18;
  localparam int c_reward_hi = 17;
  localparam int c_reward_lo = 8;
  localparam int c_weight_hi = 7;
  localparam int c_weight_lo = 0;

  typedef struct packed {
    logic [c_w_parent-1:0] parent;
    logic [c_w_action-1:0] action;
    logic                  strat;
    logic [c_w_reward-1:0] reward;
    logic [c_w_weight-1:0] weight;
  } node_fields_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONF = 3'd1,
    S_WAIT = 3'd2,
    S_PAR  = 3'd3,
    S_ACT  = 3'd4,
    S_REW  = 3'd5,
    S_WGT  = 3'd6,
    S_DONE = 3'd7
  } loader_state_t;

  // treeval stores strategy flag above the action code in a single 4-bit field
  function automatic logic [3:0] act_code(input node_fields_t f);
    return {f.strat, f.action};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tree_node_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tree_node_unpack
// Brief    : Combinational split of a packed 32-bit node word into fields.
// Revision : 1.0 - initial release
// ============================================================================
module tree_node_unpack
  import tree_loader_pkg::*;
(
  input  logic [c_node_size-1:0] i_word,
  output node_fields_t           o_fields
);

  // Pure bit slicing of the packed word into named fields
  always_comb begin
    o_fields        = '0;
    o_fields.parent = i_word[c_parent_hi:c_parent_lo];
    o_fields.action = i_word[c_action_hi:c_action_lo];
    o_fields.strat  = i_word[c_strat_bit];
    o_fields.reward = i_word[c_reward_hi:c_reward_lo];
    o_fields.weight = i_word[c_weight_hi:c_weight_lo];
  end

endmodule
`default_nettype wire

// File: rtl/tree_loader.sv
`default_nettype none
// ============================================================================
// Module   : tree_loader
// Brief    : Host-side writer for the treeval sideband load interface.
//            Takes packed node words from a valid/ready stream, programs the
//            node count, serialises each word into four field strobes and
//            pulses treeval reset when the load completes.
// Revision : 1.0 - initial release
// ============================================================================
module tree_loader
  import tree_loader_pkg::*;
#(
  parameter int W_ADDR    = 10,
  parameter int NODE_SIZE = 32,
  parameter int W_DATA    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [W_ADDR:0]      load_nodes,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [NODE_SIZE-1:0] s_data,
  input  logic                 s_last,
  output logic                 tv_conf_nodes,
  output logic [W_DATA-1:0]    tv_conf_data,
  output logic                 tv_mem_par,
  output logic                 tv_mem_act,
  output logic                 tv_mem_rew,
  output logic                 tv_mem_weight,
  output logic [W_ADDR-1:0]    tv_mem_addr,
  output logic [W_DATA-1:0]    tv_mem_data,
  output logic                 tv_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [W_ADDR:0] c_min_nodes = (W_ADDR+1)'(2);
  localparam logic [W_ADDR:0] c_max_nodes = {1'b1, {W_ADDR{1'b0}}};

  loader_state_t          r_state;
  logic [W_ADDR:0]        r_nodes;
  logic [W_ADDR-1:0]      r_idx;
  logic [NODE_SIZE-1:0]   r_node;

  logic [NODE_SIZE-1:0]   w_word;
  node_fields_t           w_fields;
  logic [W_ADDR:0]        w_last_idx;
  logic                   w_is_last;
  logic                   w_n_legal;

  // In WAIT the parent field is taken straight off the stream so PAR can
  // follow the handshake without an extra cycle; later fields use the copy.
  assign w_word     = (r_state == S_WAIT) ? s_data : r_node;
  assign w_last_idx = r_nodes - (W_ADDR+1)'(1);
  assign w_is_last  = ({1'b0, r_idx} == w_last_idx);
  assign w_n_legal  = (load_nodes >= c_min_nodes) && (load_nodes <= c_max_nodes);
  assign tv_mem_addr = r_idx;

  tree_node_unpack u_unpack (
    .i_word   (w_word),
    .o_fields (w_fields)
  );

  // Load sequencer; every output is registered and set for the state entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_nodes       <= '0;
      r_idx         <= '0;
      r_node        <= '0;
      s_ready       <= 1'b0;
      tv_conf_nodes <= 1'b0;
      tv_conf_data  <= '0;
      tv_mem_par    <= 1'b0;
      tv_mem_act    <= 1'b0;
      tv_mem_rew    <= 1'b0;
      tv_mem_weight <= 1'b0;
      tv_mem_data   <= '0;
      tv_rst        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      tv_conf_nodes <= 1'b0;
      tv_mem_par    <= 1'b0;
      tv_mem_act    <= 1'b0;
      tv_mem_rew    <= 1'b0;
      tv_mem_weight <= 1'b0;
      tv_rst        <= 1'b0;
      done          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            if (w_n_legal) begin
              r_nodes       <= load_nodes;
              r_idx         <= '0;
              err           <= 1'b0;
              busy          <= 1'b1;
              tv_conf_nodes <= 1'b1;
              tv_conf_data  <= W_DATA'(load_nodes);
              r_state       <= S_CONF;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CONF: begin
          s_ready <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (s_valid) begin
            r_node      <= s_data;
            s_ready     <= 1'b0;
            tv_mem_par  <= 1'b1;
            tv_mem_data <= W_DATA'(w_fields.parent);
            // framing mismatch is flagged but the load still runs N words
            if (s_last != w_is_last) begin
              err <= 1'b1;
            end
            r_state <= S_PAR;
          end
        end
        S_PAR: begin
          tv_mem_act  <= 1'b1;
          tv_mem_data <= W_DATA'(act_code(w_fields));
          r_state     <= S_ACT;
        end
        S_ACT: begin
          tv_mem_rew  <= 1'b1;
          tv_mem_data <= W_DATA'(w_fields.reward);
          r_state     <= S_REW;
        end
        S_REW: begin
          tv_mem_weight <= 1'b1;
          tv_mem_data   <= W_DATA'(w_fields.weight);
          r_state       <= S_WGT;
        end
        S_WGT: begin
          if (w_is_last) begin
            tv_rst  <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + W_ADDR'(1);
            s_ready <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
